// File: rtl/dbg_display.sv
// Debug display: multiplexes page-selected hex words onto a scanned 7-segment
// array, with leading-zero blanking, a hold freeze and a debounced step button.
module dbg_display #(
  parameter int NUM_DIGITS  = 8,
  parameter int PAGE_BITS   = 3,
  parameter int REFRESH_DIV = 20000,
  parameter int DB_TICKS    = 16
) (
  input  logic                                      Clk,
  input  logic                                      Rst,
  input  logic [PAGE_BITS-1:0]                      page_sel,
  input  logic [(2**PAGE_BITS)*NUM_DIGITS*4-1:0]    page_data,
  input  logic                                      hold,
  input  logic                                      blank_lz,
  input  logic                                      pb,
  output logic                                      step,
  output logic [NUM_DIGITS-1:0]                     LEDSEL,
  output logic [7:0]                                LEDOUT
);

  localparam int W  = NUM_DIGITS * 4;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(DB_TICKS + 1);

  function automatic logic [7:0] seg_enc(input logic [3:0] n);
    case (n)
      4'h0: seg_enc = 8'hC0;
      4'h1: seg_enc = 8'hF9;
      4'h2: seg_enc = 8'hA4;
      4'h3: seg_enc = 8'hB0;
      4'h4: seg_enc = 8'h99;
      4'h5: seg_enc = 8'h92;
      4'h6: seg_enc = 8'h82;
      4'h7: seg_enc = 8'hF8;
      4'h8: seg_enc = 8'h80;
      4'h9: seg_enc = 8'h90;
      4'hA: seg_enc = 8'h88;
      4'hB: seg_enc = 8'h83;
      4'hC: seg_enc = 8'hC6;
      4'hD: seg_enc = 8'hA1;
      4'hE: seg_enc = 8'h86;
      default: seg_enc = 8'h8E;
    endcase
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [W-1:0]          snap_q, snap_d;
  logic [NUM_DIGITS-1:0] ledsel_q, ledsel_d;
  logic [7:0]            ledout_q, ledout_d;
  logic [1:0]            sync_q, sync_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  stable_q, stable_d;
  logic                  step_q, step_d;

  logic                  tick;
  logic                  last_dig;
  logic [W-1:0]          upper;
  logic [7:0]            seg;

  always_comb begin
    tick     = (presc_q == PW'(REFRESH_DIV - 1));
    last_dig = (scan_q == SW'(NUM_DIGITS - 1));
    presc_d  = tick ? '0 : presc_q + 1'b1;

    scan_d = scan_q;
    if (tick) scan_d = last_dig ? '0 : scan_q + 1'b1;

    // Capture only at the frame boundary so a frame always shows one snapshot.
    snap_d = snap_q;
    if (tick && last_dig && !hold) snap_d = page_data[page_sel*W +: W];

    // Current digit and everything above it; all-zero means a leading zero.
    upper = snap_q >> {scan_q, 2'b00};
    seg   = seg_enc(upper[3:0]);
    if (blank_lz && (scan_q != '0) && (upper == '0)) seg = 8'hFF;
    else seg[7] = !(hold && (scan_q == '0));

    ledout_d = seg;
    ledsel_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_q);
  end

  always_comb begin
    sync_d   = {sync_q[0], pb};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    step_d   = 1'b0;
    if (tick) begin
      if (sync_q[1] != stable_q) begin
        if (cnt_q == CW'(DB_TICKS - 1)) begin
          stable_d = ~stable_q;
          cnt_d    = '0;
          step_d   = ~stable_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      presc_q  <= '0;
      scan_q   <= '0;
      snap_q   <= '0;
      ledsel_q <= '1;
      ledout_q <= 8'hFF;
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      scan_q   <= scan_d;
      snap_q   <= snap_d;
      ledsel_q <= ledsel_d;
      ledout_q <= ledout_d;
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      step_q   <= step_d;
    end
  end

  assign step   = step_q;
  assign LEDSEL = ledsel_q;
  assign LEDOUT = ledout_q;

endmodule
